// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
//   Shared definitions for the Morse letter transmitter and receiver:
//     - one-hot controller state encoding (IDLE, MARK, SPACE, GAP, DONE)
//     - letter ROM contents for A..H (MSB-first pattern, 1 = dash) and lengths
//     - default timing parameters, in Morse time units
//     - a small constant helper used to size the duration counter
// -----------------------------------------------------------------------------
package morse_pkg;

  // One-hot states; outputs decode directly from single state bits.
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    MARK  = 5'b00010,
    SPACE = 5'b00100,
    GAP   = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  // Default timing, in Morse units (TICK_DIV is clocks per unit).
  localparam int DEF_TICK_DIV         = 2;
  localparam int DEF_DOT_UNITS        = 1;
  localparam int DEF_DASH_UNITS       = 3;
  localparam int DEF_SYM_GAP_UNITS    = 1;
  localparam int DEF_LETTER_GAP_UNITS = 3;

  // Letter ROM. Patterns are read MSB-first; bits below the length are unused.
  localparam logic [3:0] PAT_A = 4'b0100;
  localparam logic [3:0] PAT_B = 4'b1000;
  localparam logic [3:0] PAT_C = 4'b1010;
  localparam logic [3:0] PAT_D = 4'b1000;
  localparam logic [3:0] PAT_E = 4'b0000;
  localparam logic [3:0] PAT_F = 4'b0010;
  localparam logic [3:0] PAT_G = 4'b1100;
  localparam logic [3:0] PAT_H = 4'b0000;

  localparam logic [2:0] LEN_A = 3'd2;
  localparam logic [2:0] LEN_B = 3'd4;
  localparam logic [2:0] LEN_C = 3'd4;
  localparam logic [2:0] LEN_D = 3'd3;
  localparam logic [2:0] LEN_E = 3'd1;
  localparam logic [2:0] LEN_F = 3'd4;
  localparam logic [2:0] LEN_G = 3'd3;
  localparam logic [2:0] LEN_H = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// -----------------------------------------------------------------------------
// morse_rom
//   Combinational letter lookup, shared with the receiver side.
//   Ports:
//     letter  [2:0] in   letter code, 0 = A ... 7 = H
//     pattern [3:0] out  dot/dash pattern, MSB first, 1 = dash
//     length  [2:0] out  number of symbols in the letter (1..4)
// -----------------------------------------------------------------------------
module morse_rom
  import morse_pkg::*;
(
  input  logic [2:0] letter,
  output logic [3:0] pattern,
  output logic [2:0] length
);

  always_comb begin
    pattern = '0;
    length  = '0;
    case (letter)
      3'd0: begin pattern = PAT_A; length = LEN_A; end
      3'd1: begin pattern = PAT_B; length = LEN_B; end
      3'd2: begin pattern = PAT_C; length = LEN_C; end
      3'd3: begin pattern = PAT_D; length = LEN_D; end
      3'd4: begin pattern = PAT_E; length = LEN_E; end
      3'd5: begin pattern = PAT_F; length = LEN_F; end
      3'd6: begin pattern = PAT_G; length = LEN_G; end
      3'd7: begin pattern = PAT_H; length = LEN_H; end
      default: begin pattern = '0; length = '0; end
    endcase
  end

endmodule

// File: rtl/morse_tx_ctrl.sv
// -----------------------------------------------------------------------------
// morse_tx_ctrl
//   Morse letter transmit sequencer. Accepts a letter code through a
//   start/ready handshake, looks up its pattern, then times each mark, the
//   intra-letter spaces and the closing letter gap, and pulses done.
//
//   Handshake: a letter is accepted on any rising clk edge where ready=1,
//   start=1 and abort=0; letter is captured on that same edge. start at any
//   other time is ignored and never queued.
//
//   Ports:
//     clk         in   system clock, rising edge
//     resetn      in   asynchronous active-low reset
//     start       in   send request, sampled only while ready=1
//     letter[2:0] in   letter code 0=A..7=H, captured on acceptance
//     abort       in   synchronous cancel, returns to IDLE from any state
//     ready       out  high in IDLE only
//     busy        out  high in every state except IDLE
//     mark_out    out  lamp drive, high during MARK
//     sym_strobe  out  one-cycle pulse on the last clock of each MARK
//     done        out  one-cycle pulse in DONE
//     bits_left   out  symbols not yet started (current one counts in MARK)
//     state_dbg   out  one-hot controller state, for observation
// -----------------------------------------------------------------------------
module morse_tx_ctrl
  import morse_pkg::*;
#(
  parameter int TICK_DIV         = DEF_TICK_DIV,
  parameter int DOT_UNITS        = DEF_DOT_UNITS,
  parameter int DASH_UNITS       = DEF_DASH_UNITS,
  parameter int SYM_GAP_UNITS    = DEF_SYM_GAP_UNITS,
  parameter int LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] letter,
  input  logic       abort,
  output logic       ready,
  output logic       busy,
  output logic       mark_out,
  output logic       sym_strobe,
  output logic       done,
  output logic [2:0] bits_left,
  output logic [4:0] state_dbg
);

  // Longest interval in clocks; the counter holds (interval - 1).
  localparam int MAX_CLKS = max_int(max_int(DASH_UNITS, LETTER_GAP_UNITS),
                                    max_int(DOT_UNITS, SYM_GAP_UNITS)) * TICK_DIV;
  localparam int CW = $clog2(MAX_CLKS + 1);

  localparam logic [CW-1:0] DOT_LOAD   = CW'(DOT_UNITS * TICK_DIV - 1);
  localparam logic [CW-1:0] DASH_LOAD  = CW'(DASH_UNITS * TICK_DIV - 1);
  localparam logic [CW-1:0] SPACE_LOAD = CW'(SYM_GAP_UNITS * TICK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(LETTER_GAP_UNITS * TICK_DIV - 1);

  state_t        state;
  logic [CW-1:0] cnt;        // clocks remaining in the current state, minus one
  logic [3:0]    shift_reg;  // MSB is the symbol about to be (or being) sent

  logic [3:0]    rom_pattern;
  logic [2:0]    rom_length;

  morse_rom u_rom (
    .letter  (letter),
    .pattern (rom_pattern),
    .length  (rom_length)
  );

  function automatic logic [CW-1:0] mark_load(input logic is_dash);
    return is_dash ? DASH_LOAD : DOT_LOAD;
  endfunction

  // Controller. sym_strobe is registered: it is set on the edge that enters
  // the final MARK clock (either on MARK entry for a 1-clock mark, or when the
  // counter steps from 1 to 0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_reg  <= '0;
      bits_left  <= '0;
      sym_strobe <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      if (abort) begin
        // Cancel wins over everything; in IDLE it simply blocks acceptance.
        state     <= IDLE;
        cnt       <= '0;
        shift_reg <= '0;
        bits_left <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= MARK;
              shift_reg  <= rom_pattern;
              bits_left  <= rom_length;
              cnt        <= mark_load(rom_pattern[3]);
              sym_strobe <= (mark_load(rom_pattern[3]) == '0);
            end
          end

          MARK: begin
            if (cnt == '0) begin
              shift_reg <= {shift_reg[2:0], 1'b0};
              bits_left <= bits_left - 3'd1;
              if (bits_left > 3'd1) begin
                state <= SPACE;
                cnt   <= SPACE_LOAD;
              end else begin
                state <= GAP;
                cnt   <= GAP_LOAD;
              end
            end else begin
              cnt <= cnt - 1'b1;
              if (cnt == CW'(1)) sym_strobe <= 1'b1;
            end
          end

          SPACE: begin
            if (cnt == '0) begin
              // Register was already shifted on MARK exit.
              state      <= MARK;
              cnt        <= mark_load(shift_reg[3]);
              sym_strobe <= (mark_load(shift_reg[3]) == '0);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end

          GAP: begin
            if (cnt == '0) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end

          DONE: begin
            // Single cycle; a start pending here waits for IDLE.
            state <= IDLE;
            cnt   <= '0;
          end

          default: begin
            state     <= IDLE;
            cnt       <= '0;
            shift_reg <= '0;
            bits_left <= '0;
          end
        endcase
      end
    end
  end

  // Decoded straight from the one-hot state register.
  assign ready     = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mark_out  = (state == MARK);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_morse_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_morse_tx_ctrl
//   Cycle-by-cycle trace check of morse_tx_ctrl. Two instances: TICK_DIV=2
//   (default) and TICK_DIV=1; "sel" chooses which one is driven and observed.
// -----------------------------------------------------------------------------
module tb_morse_tx_ctrl;
  import morse_pkg::*;

  localparam int W = 13;  // {state, ready, busy, mark, strobe, done, bits_left}

  // Unit lengths from the letter timing definition.
  localparam int U_DOT  = 1;
  localparam int U_DASH = 3;
  localparam int U_SYM  = 1;
  localparam int U_GAP  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [2:0] letter = 3'd0;
  logic       abort = 1'b0;
  logic       sel = 1'b0;

  logic start_a, abort_a, start_b, abort_b;
  assign start_a = start & ~sel;
  assign abort_a = abort & ~sel;
  assign start_b = start & sel;
  assign abort_b = abort & sel;

  logic       ready_a, busy_a, mark_a, strobe_a, done_a;
  logic [2:0] bits_a;
  logic [4:0] state_a;
  logic       ready_b, busy_b, mark_b, strobe_b, done_b;
  logic [2:0] bits_b;
  logic [4:0] state_b;

  morse_tx_ctrl dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .letter(letter), .abort(abort_a),
    .ready(ready_a), .busy(busy_a), .mark_out(mark_a), .sym_strobe(strobe_a),
    .done(done_a), .bits_left(bits_a), .state_dbg(state_a)
  );

  morse_tx_ctrl #(.TICK_DIV(1)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .letter(letter), .abort(abort_b),
    .ready(ready_b), .busy(busy_b), .mark_out(mark_b), .sym_strobe(strobe_b),
    .done(done_b), .bits_left(bits_b), .state_dbg(state_b)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int push_budget = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp_v);
    end
  endtask

  function automatic logic [W-1:0] observed();
    if (sel) return {state_b, ready_b, busy_b, mark_b, strobe_b, done_b, bits_b};
    return {state_a, ready_a, busy_a, mark_a, strobe_a, done_a, bits_a};
  endfunction

  function automatic logic [W-1:0] mk(input state_t st, input logic m, input logic s, input int b);
    return {st, st == IDLE, st != IDLE, m, s, st == DONE, 3'(b)};
  endfunction

  // Independent copy of the letter table (pattern MSB-first, 1 = dash).
  task automatic tb_rom(input int l, output logic [3:0] p, output int n);
    case (l)
      0: begin p = 4'b0100; n = 2; end
      1: begin p = 4'b1000; n = 4; end
      2: begin p = 4'b1010; n = 4; end
      3: begin p = 4'b1000; n = 3; end
      4: begin p = 4'b0000; n = 1; end
      5: begin p = 4'b0010; n = 4; end
      6: begin p = 4'b1100; n = 3; end
      default: begin p = 4'b0000; n = 4; end
    endcase
  endtask

  task automatic push_exp(input logic [W-1:0] v);
    if (push_budget > 0) begin
      exp_q.push_back(v);
      push_budget--;
    end
  endtask

  // Expected per-clock outputs from the acceptance edge up to and including DONE.
  task automatic push_letter(input int l, input int t);
    logic [3:0] p;
    int n;
    int m;
    tb_rom(l, p, n);
    for (int i = 0; i < n; i++) begin
      m = (p[3-i] ? U_DASH : U_DOT) * t;
      for (int c = 0; c < m; c++) push_exp(mk(MARK, 1'b1, c == m - 1, n - i));
      if (i < n - 1)
        for (int c = 0; c < U_SYM * t; c++) push_exp(mk(SPACE, 1'b0, 1'b0, n - i - 1));
      else
        for (int c = 0; c < U_GAP * t; c++) push_exp(mk(GAP, 1'b0, 1'b0, 0));
    end
    push_exp(mk(DONE, 1'b0, 1'b0, 0));
  endtask

  // One clock: sample #2 after the rising edge, compare against the queue head.
  task automatic cycle();
    logic [W-1:0] e;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("trace", observed(), e);
    end
  endtask

  // ---------------- driver ----------------
  // Sends one letter and checks it through the following IDLE cycle. With
  // hold=0, start and letter are scrambled while busy (must have no effect).
  task automatic send(input int l, input bit hold);
    int t;
    t = sel ? 1 : 2;
    letter = 3'(l);
    start = 1'b1;
    push_budget = 1000;
    push_letter(l, t);
    exp_q.push_back(mk(IDLE, 1'b0, 1'b0, 0));
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) begin
      cycle();
      if (exp_q.size() > 0 && !hold) begin
        start  = 1'($urandom_range(0, 1));
        letter = 3'($urandom_range(0, 7));
      end
    end
    start = hold;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #2;
    check_eq("reset_a", {state_a, ready_a, busy_a, mark_a, strobe_a, done_a, bits_a},
             mk(IDLE, 1'b0, 1'b0, 0));
    check_eq("reset_b", {state_b, ready_b, busy_b, mark_b, strobe_b, done_b, bits_b},
             mk(IDLE, 1'b0, 1'b0, 0));
    resetn = 1'b1;
    exp_q.push_back(mk(IDLE, 1'b0, 1'b0, 0));
    cycle();

    // E and A at TICK_DIV=2
    send(4, 1'b0);
    send(0, 1'b0);

    // C at TICK_DIV=1
    sel = 1'b1;
    send(2, 1'b0);
    sel = 1'b0;

    // H with start held: back-to-back letters
    send(7, 1'b1);
    send(7, 1'b1);
    send(7, 1'b0);

    // abort in IDLE blocks acceptance
    letter = 3'd0;
    start  = 1'b1;
    abort  = 1'b1;
    exp_q.push_back(mk(IDLE, 1'b0, 1'b0, 0));
    cycle();
    abort = 1'b0;
    start = 1'b0;
    exp_q.push_back(mk(IDLE, 1'b0, 1'b0, 0));
    cycle();

    // abort in the second MARK of B, then a fresh start
    letter = 3'd1;
    start  = 1'b1;
    push_budget = 9;  // 6-clock dash, 2-clock space, first clock of the dot
    push_letter(1, 2);
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      cycle();
      start = 1'b0;
    end
    abort = 1'b1;
    exp_q.push_back(mk(IDLE, 1'b0, 1'b0, 0));
    cycle();
    abort = 1'b0;
    send(4, 1'b0);

    // asynchronous reset mid-dash of G, then G sent normally
    letter = 3'd6;
    start  = 1'b1;
    push_budget = 3;
    push_letter(6, 2);
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      cycle();
      start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    check_eq("async_reset", observed(), mk(IDLE, 1'b0, 1'b0, 0));
    @(posedge clk);
    #2;
    resetn = 1'b1;
    exp_q.push_back(mk(IDLE, 1'b0, 1'b0, 0));
    cycle();
    send(6, 1'b0);

    // a few random letters on each instance
    for (int i = 0; i < 4; i++) begin
      sel = 1'(i % 2);
      send(int'($urandom_range(0, 7)), 1'b0);
    end
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
